// File: rtl/watch_pkg.sv
// Shared definitions for the watch set-mode logic.
//   edit_state_e          : set-mode controller states
//   FLD_SEC/FLD_MIN/FLD_HOUR : cursor index of each time field (0 = least significant)
//   DEFAULT_TIMEOUT_TICKS : idle ticks before editing is abandoned
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EDIT    = 2'd1,
    ST_LOCKOUT = 2'd2
  } edit_state_e;

  localparam int FLD_SEC  = 0;
  localparam int FLD_MIN  = 1;
  localparam int FLD_HOUR = 2;

  localparam int DEFAULT_TIMEOUT_TICKS = 10;

endpackage

// File: rtl/edit_timeout_ctr.sv
// Idle-tick counter for set mode.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : return the count to 0 (key pressed or not editing)
//   tick_i     : timebase pulse
//   en_i       : count ticks only while set
//   expire_o   : 1-cycle pulse on the TIMEOUT_TICKS-th consecutive idle tick
// TIMEOUT_TICKS = 0 disables expiry.
module edit_timeout_ctr #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic tick_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'((TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_tick;

  assign cnt_tick = en_i && tick_i && !clear_i;

  // Expiry fires on the tick that would take the count past TERM.
  assign expire_o = (TIMEOUT_TICKS != 0) && cnt_tick && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_tick && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_edit_cu.sv
// Set-mode controller for the clock datapath: walks an edit cursor over the
// time fields, issues inc/dec strobes, blinks the selected field and abandons
// editing after a run of idle ticks.
//   clk, rst          : clock, asynchronous active-high reset
//   i_tick            : timebase pulse (blink / timeout)
//   i_edit_en         : edit mode switch level
//   i_left / i_right  : cursor to more / less significant field (pulses)
//   i_up / i_down     : increment / decrement selected field (pulses)
//   o_idle            : not editing
//   o_field_sel       : one-hot field being edited (0 outside EDIT)
//   o_field_idx       : cursor index (0 outside EDIT)
//   o_inc / o_dec     : registered 1-cycle adjust strobes
//   o_blink           : display enable for the selected field
//   o_timeout         : in LOCKOUT
module time_edit_cu
  import watch_pkg::*;
#(
  parameter int NUM_FIELDS    = 3,
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
  parameter int IDX_W         = $clog2(NUM_FIELDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tick,
  input  logic                  i_edit_en,
  input  logic                  i_left,
  input  logic                  i_right,
  input  logic                  i_up,
  input  logic                  i_down,
  output logic                  o_idle,
  output logic [NUM_FIELDS-1:0] o_field_sel,
  output logic [IDX_W-1:0]      o_field_idx,
  output logic                  o_inc,
  output logic                  o_dec,
  output logic                  o_blink,
  output logic                  o_timeout
);

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(FLD_SEC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_FIELDS - 1);

  edit_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_FIELDS-1:0]   sel_q, sel_d;
  logic                    inc_q, inc_d;
  logic                    dec_q, dec_d;
  logic                    blink_q, blink_d;
  logic                    key;
  logic                    ctr_en;
  logic                    ctr_clear;
  logic                    expire;

  assign key       = i_left | i_right | i_up | i_down;
  assign ctr_en    = (state_q == ST_EDIT) && i_edit_en;
  assign ctr_clear = !ctr_en || key;

  edit_timeout_ctr #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (ctr_clear),
    .tick_i   (i_tick),
    .en_i     (ctr_en),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blink_d = 1'b1;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = IDX_FIRST;
        if (i_edit_en) state_d = ST_EDIT;
      end
      ST_EDIT: begin
        if (!i_edit_en) begin
          // Switch drop wins over any key pending in the same cycle.
          state_d = ST_IDLE;
          idx_d   = IDX_FIRST;
        end else begin
          if (i_left && !i_right) begin
            idx_d = (idx_q == IDX_LAST) ? IDX_FIRST : idx_q + 1'b1;
          end else if (i_right && !i_left) begin
            idx_d = (idx_q == IDX_FIRST) ? IDX_LAST : idx_q - 1'b1;
          end
          inc_d = i_up && !i_down;
          dec_d = i_down && !i_up;
          if (key) begin
            blink_d = 1'b1;
          end else if (i_tick) begin
            blink_d = !blink_q;
          end
          if (expire) begin
            state_d = ST_LOCKOUT;
            idx_d   = IDX_FIRST;
            blink_d = 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        idx_d = IDX_FIRST;
        if (!i_edit_en) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_FIRST;
      end
    endcase
    // Select follows the pre-move cursor so it lines up with the strobe.
    sel_d = (state_d == ST_EDIT) ? (NUM_FIELDS'(1) << idx_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_FIRST;
      sel_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      blink_q <= blink_d;
    end
  end

  assign o_idle      = (state_q != ST_EDIT);
  assign o_field_sel = sel_q;
  assign o_field_idx = idx_q;
  assign o_inc       = inc_q;
  assign o_dec       = dec_q;
  assign o_blink     = blink_q;
  assign o_timeout   = (state_q == ST_LOCKOUT);

endmodule
